// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one repeated-addition multiplier among N requesters
//
// Build option: define MUL_ARB_BYPASS_EN to answer trivial operands (A==0, B==0, A==1)
// directly from IDLE without starting the multiplier.
//
// Ports:
//   Clk_i        clock, all logic on posedge
//   Rst_n_i      synchronous active-low reset
//   req_i        per-requester request level
//   req_b_i      flattened 64-bit B operands, requester i at [i*64 +: 64]
//   req_a_i      flattened 32-bit A operands, requester i at [i*32 +: 32]
//   gnt_o        one-hot grant, high from issue through completion
//   done_o       one-cycle completion pulse to the granted requester
//   res_o        product, valid with done, held until the next completion
//   busy_o       high whenever the arbiter is not idle
//   mul_b_o      registered B operand to the multiplier
//   mul_a_o      registered A operand to the multiplier
//   mul_start_o  one-cycle start pulse to the multiplier
//   mul_r_i      multiplier result
//   mul_ack_i    multiplier ack, sticky until the next start is accepted
module mul_arbiter #(
   parameter int N  = 4,
   parameter int IW = 3
) (
   input  logic            Clk_i,
   input  logic            Rst_n_i,
   input  logic [N-1:0]    req_i,
   input  logic [N*64-1:0] req_b_i,
   input  logic [N*32-1:0] req_a_i,
   output logic [N-1:0]    gnt_o,
   output logic [N-1:0]    done_o,
   output logic [63:0]     res_o,
   output logic            busy_o,
   output logic [63:0]     mul_b_o,
   output logic [31:0]     mul_a_o,
   output logic            mul_start_o,
   input  logic [63:0]     mul_r_i,
   input  logic            mul_ack_i
);
   typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, DONE} state_t;
   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
   logic [N-1:0]    gnt_q, gnt_d, done_q, done_d;
   logic [63:0]     res_q, res_d, mul_b_q, mul_b_d;
   logic [31:0]     mul_a_q, mul_a_d;
   logic            busy_q, busy_d, mul_start_q, mul_start_d;
   logic            any, byp;
   logic [N-1:0]    rot;
   logic [IW-1:0]   off, w;
   logic [IW:0]     sum;
   logic [63:0]     wb;
   logic [31:0]     wa;
   assign any = |req_i;
   // Rotate requests so bit 0 is the pointer position; the lowest set bit is the winner offset.
   always_comb begin
      rot = N'({req_i, req_i} >> ptr_q);
      off = '0;
      for (int j = N - 1; j >= 0; j--)
         if (rot[j]) off = IW'(j);
      sum = {1'b0, ptr_q} + {1'b0, off};
      w = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      wb = '0;
      wa = '0;
      for (int i = 0; i < N; i++)
         if (w == IW'(i)) begin
            wb = req_b_i[i*64 +: 64];
            wa = req_a_i[i*32 +: 32];
         end
   end
`ifdef MUL_ARB_BYPASS_EN
   assign byp = (wa == 32'd0) || (wb == 64'd0) || (wa == 32'd1);
`else
   assign byp = 1'b0;
`endif
   always_ff @(posedge Clk_i) begin
      if (!Rst_n_i) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         idx_q       <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         res_q       <= '0;
         busy_q      <= 1'b0;
         mul_start_q <= 1'b0;
         mul_b_q     <= '0;
         mul_a_q     <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         idx_q       <= idx_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         res_q       <= res_d;
         busy_q      <= busy_d;
         mul_start_q <= mul_start_d;
         mul_b_q     <= mul_b_d;
         mul_a_q     <= mul_a_d;
      end
   end
   // ISSUE and SETTLE never look at mul_ack_i: the previous operation's ack can still be high there.
   always_comb begin
      state_d = (state_q == IDLE)   ? (any ? (byp ? DONE : ISSUE) : IDLE) :
                (state_q == ISSUE)  ? SETTLE :
                (state_q == SETTLE) ? WAIT :
                (state_q == WAIT)   ? (mul_ack_i ? DONE : WAIT) : IDLE;
   end
   always_comb begin
      ptr_d       = ptr_q;
      idx_d       = idx_q;
      gnt_d       = gnt_q;
      done_d      = '0;
      res_d       = res_q;
      busy_d      = busy_q;
      mul_start_d = 1'b0;
      mul_b_d     = mul_b_q;
      mul_a_d     = mul_a_q;
      if (state_q == IDLE && any) begin
         idx_d  = w;
         gnt_d  = N'(1) << w;
         busy_d = 1'b1;
         if (byp) begin
            res_d  = (wa == 32'd1) ? wb : '0;
            done_d = N'(1) << w;
         end else begin
            mul_start_d = 1'b1;
            mul_b_d     = wb;
            mul_a_d     = wa;
         end
      end
      if (state_q == WAIT && mul_ack_i) begin
         res_d  = mul_r_i;
         done_d = N'(1) << idx_q;
      end
      if (state_q == DONE) begin
         gnt_d  = '0;
         busy_d = 1'b0;
         ptr_d  = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
      end
   end
   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign res_o       = res_q;
   assign busy_o      = busy_q;
   assign mul_b_o     = mul_b_q;
   assign mul_a_o     = mul_a_q;
   assign mul_start_o = mul_start_q;
endmodule
